button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N_BTN, 2, number of independent button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles required to accept a level change (10 ms at 50 MHz); SHALL be >= 2.
REQ-003 Parameter ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed, 0 = reads 1 when pressed.
REQ-004 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 btn_raw  input  N_BTN  raw, asynchronous, bouncing push-button levels.
REQ-007 btn_level  output  N_BTN  debounced level, 1 = pressed, independent of ACTIVE_LOW.
REQ-008 btn_press  output  N_BTN  one-cycle pulse per accepted press; drives the clock/reset inputs of the downstream 2-bit D register.
REQ-009 btn_release  output  N_BTN  one-cycle pulse per accepted release.

Function
REQ-010 Each channel SHALL pass btn_raw through a 2-flop synchronizer before any other logic uses it.
REQ-011 The synchronized value SHALL be XORed with ACTIVE_LOW to give normalized p (1 = pressed).
REQ-012 Each channel SHALL own one FSM with states STABLE_LO, PEND_HI, STABLE_HI, PEND_LO, plus a counter of width clog2(DEBOUNCE_CYCLES).
REQ-013 STABLE_LO: p=1 -> PEND_HI with counter cleared to 0; p=0 -> stay.
REQ-014 PEND_HI: p=0 -> STABLE_LO with no pulse; p=1 with counter < DEBOUNCE_CYCLES-1 -> increment; p=1 with counter == DEBOUNCE_CYCLES-1 -> STABLE_HI.
REQ-015 STABLE_HI: p=0 -> PEND_LO with counter cleared; p=1 -> stay.
REQ-016 PEND_LO: mirror of PEND_HI; p=1 aborts to STABLE_HI with no pulse; completed window -> STABLE_LO.
REQ-017 btn_level SHALL be a registered output, 1 exactly while the state is STABLE_HI or PEND_LO.
REQ-018 btn_press SHALL be registered and high for exactly one cycle, following the edge of the PEND_HI->STABLE_HI transition.
REQ-019 btn_release SHALL be registered and high for exactly one cycle, following the edge of the PEND_LO->STABLE_LO transition.
REQ-020 Latency: if btn_raw is held active from before edge 1, where edge 1 is the first edge to sample it, btn_press and btn_level SHALL go high after edge DEBOUNCE_CYCLES+3; btn_press SHALL drop after edge DEBOUNCE_CYCLES+4.
REQ-021 Release latency SHALL equal press latency.
REQ-022 Any bounce shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no pulse and no btn_level change.
REQ-023 A held button SHALL produce exactly one btn_press; there is no auto-repeat.
REQ-024 btn_press and btn_release SHALL never both be high on the same channel in the same cycle.
REQ-025 Channels SHALL be fully independent; simultaneous qualifying presses SHALL pulse in the same cycle.
REQ-026 The counter SHALL never wrap; it is cleared on every entry to a PEND state.

Reset
REQ-027 While rst=1: synchronizer flops SHALL hold the inactive raw level (ACTIVE_LOW value); FSM = STABLE_LO; counter = 0; btn_level = btn_press = btn_release = 0.
REQ-028 Reset asserted mid-PEND SHALL abort the window; no pulse SHALL appear during or after reset for that window.
REQ-029 A button held active through reset release SHALL be treated as a new press: full latency per REQ-020, counted from the first edge after rst falls, then one btn_press.
REQ-030 No btn_release SHALL be generated by reset itself.

Verification (N_BTN=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1)
REQ-031 Clean press: btn_raw[0] 1->0 and held -> btn_level[0]=1 and btn_press[0]=1 after edge 7; btn_press[0]=0 after edge 8; channel 1 outputs stay 0.
REQ-032 Bounce: btn_raw[0] low 3 cycles, high 1 cycle, then low and held -> no pulse during the bounce; single btn_press[0] 7 edges after the final falling sample.
REQ-033 Release: from pressed, btn_raw[0] -> 1 held -> btn_release[0] one cycle after edge 7, btn_level[0]=0; btn_press[0] stays 0.
REQ-034 Simultaneous: both raw bits fall on the same edge -> btn_press=2'b11 for one cycle after edge 7.
REQ-035 Reset mid-PEND: press, then rst pulse at edge 5 with button still held -> all outputs 0 during rst; btn_press[0] after the 7th edge following rst deassertion; exactly one pulse in total.
REQ-036 Held button: hold pressed 100 cycles -> exactly one btn_press[0] and no btn_release[0].

Source files
------------

// File: rtl/button_conditioner.sv
// Per-channel push-button conditioner with a synchronizer and a debounce FSM.
// Each channel emits a debounced level plus one-cycle press and release pulses.
module button_conditioner #(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [N_BTN-1:0] IDLE_RAW = {N_BTN{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    STABLE_LO,
    PEND_HI,
    STABLE_HI,
    PEND_LO
  } state_e;

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] p;

  // Reset parks the synchronizer at the released level so reset never
  // looks like a press or a release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= IDLE_RAW;
      sync2_q <= IDLE_RAW;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  assign p = sync2_q ^ IDLE_RAW;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    state_e          state_q;
    state_e          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            level_d;
    logic            press_d;
    logic            release_d;
    logic            level_q;
    logic            press_q;
    logic            release_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= STABLE_LO;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        STABLE_LO: begin
          if (p[g]) begin
            state_d = PEND_HI;
            cnt_d   = '0;
          end
        end
        PEND_HI: begin
          if (!p[g]) begin
            state_d = STABLE_LO;
          end else if (cnt_q == CNT_MAX) begin
            state_d = STABLE_HI;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STABLE_HI: begin
          if (!p[g]) begin
            state_d = PEND_LO;
            cnt_d   = '0;
          end
        end
        PEND_LO: begin
          if (p[g]) begin
            state_d = STABLE_HI;
          end else if (cnt_q == CNT_MAX) begin
            state_d = STABLE_LO;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end
      endcase
    end

    // Decoded from the next state so the registered outputs track the
    // state register cycle for cycle.
    always_comb begin
      level_d   = (state_d == STABLE_HI) || (state_d == PEND_LO);
      press_d   = (state_q == PEND_HI) && (state_d == STABLE_HI);
      release_d = (state_q == PEND_LO) && (state_d == STABLE_LO);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign btn_level[g]   = level_q;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = release_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a pulse scoreboard.
// Stimulus queues expected pulses; a negedge monitor matches them.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] level;
  } ev_t;

  ev_t exp_q[$];

  button_conditioner #(
    .N_BTN(2),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, expv, cyc);
    end
  endtask

  task automatic push(input int at, input logic [1:0] pr,
                      input logic [1:0] rl, input logic [1:0] lv);
    ev_t e;
    e.cyc = at;
    e.press = pr;
    e.rel = rl;
    e.level = lv;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Any press or release pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    ev_t e;
    if ((btn_press | btn_release) !== 2'b00) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: press=%b release=%b at cycle %0d",
                 btn_press, btn_release, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_press", int'(btn_press), int'(e.press));
        check("pulse_release", int'(btn_release), int'(e.rel));
        check("pulse_level", int'(btn_level), int'(e.level));
      end
    end
  end

  initial begin
    rst = 1'b1;
    btn_raw = 2'b11;
    step(3);
    check("rst_level", int'(btn_level), 0);
    check("rst_press", int'(btn_press), 0);
    check("rst_release", int'(btn_release), 0);
    rst = 1'b0;
    step(5);
    check("idle_level", int'(btn_level), 0);

    // clean press on channel 0
    btn_raw = 2'b10;
    push(cyc + 7, 2'b01, 2'b00, 2'b01);
    step(20);
    check("press_level", int'(btn_level), 1);

    // clean release
    btn_raw = 2'b11;
    push(cyc + 7, 2'b00, 2'b01, 2'b00);
    step(20);
    check("release_level", int'(btn_level), 0);

    // bounce: low 3, high 1, then low held
    btn_raw = 2'b10;
    step(3);
    btn_raw = 2'b11;
    step(1);
    btn_raw = 2'b10;
    push(cyc + 7, 2'b01, 2'b00, 2'b01);
    step(20);
    check("bounce_level", int'(btn_level), 1);
    btn_raw = 2'b11;
    push(cyc + 7, 2'b00, 2'b01, 2'b00);
    step(20);

    // both channels on the same edge
    btn_raw = 2'b00;
    push(cyc + 7, 2'b11, 2'b00, 2'b11);
    step(20);
    check("simul_level", int'(btn_level), 3);
    btn_raw = 2'b11;
    push(cyc + 7, 2'b00, 2'b11, 2'b00);
    step(20);
    check("simul_rel_level", int'(btn_level), 0);

    // reset in the middle of a pending press window
    btn_raw = 2'b10;
    step(4);
    rst = 1'b1;
    step(1);
    check("midrst_level", int'(btn_level), 0);
    check("midrst_press", int'(btn_press), 0);
    check("midrst_release", int'(btn_release), 0);
    step(1);
    rst = 1'b0;
    push(cyc + 7, 2'b01, 2'b00, 2'b01);
    step(20);
    check("postrst_level", int'(btn_level), 1);

    // long hold: no repeat, no release
    step(100);
    check("held_level", int'(btn_level), 1);
    btn_raw = 2'b11;
    push(cyc + 7, 2'b00, 2'b01, 2'b00);
    step(20);
    check("final_level", int'(btn_level), 0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
